// File: rtl/scarv_cop_malu_seq.sv
// Issue-side sequencer for the COP multi-precision ALU: IDLE -> BUSY -> WB -> RSP.
// Optional BUSY watchdog enabled by defining SCARV_COP_MALU_TIMEOUT_EN.
module scarv_cop_malu_seq #(
  parameter int CPR_AW         = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              g_clk,
  input  logic              g_reset,
  input  logic              insn_valid,
  output logic              insn_ready,
  input  logic [CPR_AW-1:0] insn_rd,
  output logic              malu_ivalid,
  input  logic              malu_idone,
  input  logic [3:0]        malu_cpr_rd_ben,
  input  logic [31:0]       malu_cpr_rd_wdata,
  output logic [3:0]        cpr_rd_wen,
  output logic [CPR_AW-1:0] cpr_rd_addr,
  output logic [31:0]       cpr_rd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_status
);

  // Handshakes: insn transfers when insn_valid && insn_ready at a rising edge;
  // rsp transfers when rsp_valid && rsp_ready; rsp_valid/rsp_status hold until then.
  typedef enum logic [1:0] {IDLE, BUSY, WB, RSP} state_t;

  state_t            state;
  logic [CPR_AW-1:0] rd_q;
`ifdef SCARV_COP_MALU_TIMEOUT_EN
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0]        wait_cnt;
`endif

  assign insn_ready = (state == IDLE);

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state        <= IDLE;
      rd_q         <= '0;
      malu_ivalid  <= 1'b0;
      cpr_rd_wen   <= 4'b0;
      cpr_rd_addr  <= '0;
      cpr_rd_wdata <= 32'b0;
      rsp_valid    <= 1'b0;
      rsp_status   <= 2'd0;
`ifdef SCARV_COP_MALU_TIMEOUT_EN
      wait_cnt     <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (insn_valid) begin
            rd_q        <= insn_rd;
            malu_ivalid <= 1'b1;
            state       <= BUSY;
`ifdef SCARV_COP_MALU_TIMEOUT_EN
            wait_cnt    <= 8'd0;
`endif
          end
        end
        BUSY: begin
          // Completion is checked first so idone on the terminal count still wins.
          if (malu_idone) begin
            malu_ivalid  <= 1'b0;
            cpr_rd_wen   <= (rd_q == '0) ? 4'b0 : malu_cpr_rd_ben;
            cpr_rd_addr  <= rd_q;
            cpr_rd_wdata <= malu_cpr_rd_wdata;
            state        <= WB;
          end
`ifdef SCARV_COP_MALU_TIMEOUT_EN
          else if (wait_cnt == LAST_WAIT) begin
            malu_ivalid <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_status  <= 2'd1;
            state       <= RSP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end
        WB: begin
          cpr_rd_wen <= 4'b0;
          rsp_valid  <= 1'b1;
          rsp_status <= 2'd0;
          state      <= RSP;
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            rsp_status <= 2'd0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scarv_cop_malu_seq.sv
// Self-checking bench for scarv_cop_malu_seq: directed cases plus randomized
// transactions against a transaction-level expectation model.
module tb_scarv_cop_malu_seq;

  logic        clk = 1'b0;
  logic        g_reset;
  logic        insn_valid;
  logic        insn_ready;
  logic [3:0]  insn_rd;
  logic        malu_ivalid;
  logic        malu_idone;
  logic [3:0]  malu_cpr_rd_ben;
  logic [31:0] malu_cpr_rd_wdata;
  logic [3:0]  cpr_rd_wen;
  logic [3:0]  cpr_rd_addr;
  logic [31:0] cpr_rd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_status;

  int n_checks = 0;
  int n_pass   = 0;

  // Observations of the most recent transaction
  int          obs_lat, obs_writes, obs_ivalid, obs_rsp_cycles;
  logic [3:0]  obs_ben, obs_addr;
  logic [31:0] obs_data;
  logic [1:0]  obs_status;
  bit          obs_status_stable, obs_ready_bad, obs_idle;

  logic [39:0] exp_q[$];

  always #5 clk = ~clk;

  scarv_cop_malu_seq #(.CPR_AW(4), .TIMEOUT_CYCLES(8)) dut (
    .g_clk(clk), .g_reset(g_reset),
    .insn_valid(insn_valid), .insn_ready(insn_ready), .insn_rd(insn_rd),
    .malu_ivalid(malu_ivalid), .malu_idone(malu_idone),
    .malu_cpr_rd_ben(malu_cpr_rd_ben), .malu_cpr_rd_wdata(malu_cpr_rd_wdata),
    .cpr_rd_wen(cpr_rd_wen), .cpr_rd_addr(cpr_rd_addr), .cpr_rd_wdata(cpr_rd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status)
  );

  // Issue one instruction and play the MALU: idone in BUSY cycle delay+1.
  // rsp_ready is withheld for rsp_wait RSP cycles. Cycle c counts from accept.
  task automatic run_insn(input logic [3:0] rd, input int delay, input logic [3:0] ben,
                          input logic [31:0] data, input int rsp_wait);
    bit fin;
    obs_lat = 0; obs_writes = 0; obs_ivalid = 0; obs_rsp_cycles = 0;
    obs_ben = 0; obs_addr = 0; obs_data = 0; obs_status = 0;
    obs_status_stable = 1; obs_ready_bad = 0; obs_idle = 0;
    @(negedge clk);
    insn_valid = 1'b1;
    insn_rd    = rd;
    @(posedge clk);
    @(negedge clk);
    insn_valid = 1'b0;
    insn_rd    = 4'($urandom);
    for (int c = 1; c <= 400; c++) begin
      if (malu_ivalid) obs_ivalid++;
      malu_idone        = malu_ivalid && (obs_ivalid == delay + 1);
      malu_cpr_rd_ben   = malu_idone ? ben  : 4'($urandom);
      malu_cpr_rd_wdata = malu_idone ? data : $urandom;
      if (cpr_rd_wen != 4'b0) begin
        obs_writes++;
        obs_ben  = cpr_rd_wen;
        obs_addr = cpr_rd_addr;
        obs_data = cpr_rd_wdata;
      end
      if (rsp_valid) begin
        if (obs_rsp_cycles == 0) begin
          obs_lat    = c;
          obs_status = rsp_status;
        end else if (rsp_status !== obs_status) begin
          obs_status_stable = 0;
        end
        if (insn_ready) obs_ready_bad = 1;
        obs_rsp_cycles++;
        rsp_ready = (obs_rsp_cycles > rsp_wait);
      end
      fin = rsp_valid && rsp_ready;
      @(posedge clk);
      @(negedge clk);
      if (fin) break;
    end
    malu_idone = 1'b0;
    rsp_ready  = 1'b0;
    obs_idle   = insn_ready && !rsp_valid && !malu_ivalid;
  endtask

  task automatic test_reset();
    g_reset = 1'b1;
    insn_valid = 0; insn_rd = 0; malu_idone = 0; malu_cpr_rd_ben = 0;
    malu_cpr_rd_wdata = 0; rsp_ready = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({insn_ready, malu_ivalid, cpr_rd_wen, rsp_valid, rsp_status} !== 9'b1_0_0000_0_00)
      $display("FAIL reset_outputs got ready=%b ivalid=%b wen=%b rsp=%b st=%0d want 1 0 0000 0 0",
               insn_ready, malu_ivalid, cpr_rd_wen, rsp_valid, rsp_status);
    else n_pass++;
    g_reset = 1'b0;
    @(negedge clk);
    insn_valid = 1'b1; insn_rd = 4'd7;
    @(posedge clk);
    @(negedge clk);
    insn_valid = 1'b0;
    n_checks++;
    if (malu_ivalid !== 1'b1 || insn_ready !== 1'b0)
      $display("FAIL busy_entry got ivalid=%b ready=%b want 1 0", malu_ivalid, insn_ready);
    else n_pass++;
    @(negedge clk);
    g_reset = 1'b1;
    #1;
    n_checks++;
    if ({insn_ready, malu_ivalid, cpr_rd_wen, rsp_valid} !== 7'b1_0_0000_0)
      $display("FAIL reset_mid_busy got ready=%b ivalid=%b wen=%b rsp=%b want 1 0 0000 0",
               insn_ready, malu_ivalid, cpr_rd_wen, rsp_valid);
    else n_pass++;
    @(negedge clk);
    g_reset = 1'b0;
    malu_idone = 1'b1; malu_cpr_rd_ben = 4'hF; malu_cpr_rd_wdata = 32'hCAFEF00D;
    @(negedge clk);
    malu_idone = 1'b0;
    obs_writes = 0; obs_rsp_cycles = 0;
    repeat (5) begin
      if (cpr_rd_wen != 0) obs_writes++;
      if (rsp_valid || malu_ivalid) obs_rsp_cycles++;
      @(negedge clk);
    end
    n_checks++;
    if (obs_writes !== 0 || obs_rsp_cycles !== 0)
      $display("FAIL reset_abandon got writes=%0d activity=%0d want 0 0", obs_writes, obs_rsp_cycles);
    else n_pass++;
  endtask

  task automatic test_directed();
    run_insn(4'd3, 0, 4'hF, 32'hDEADBEEF, 0);
    n_checks++;
    if (obs_lat !== 3 || obs_status !== 2'd0)
      $display("FAIL min_latency got lat=%0d st=%0d want 3 0", obs_lat, obs_status);
    else n_pass++;
    n_checks++;
    if (obs_writes !== 1 || {obs_ben, obs_addr, obs_data} !== {4'hF, 4'd3, 32'hDEADBEEF})
      $display("FAIL write_c3 got n=%0d wen=%h addr=%0d data=%h want 1 f 3 deadbeef",
               obs_writes, obs_ben, obs_addr, obs_data);
    else n_pass++;
    n_checks++;
    if (obs_idle !== 1'b1 || obs_ivalid !== 1)
      $display("FAIL return_idle got idle=%b ivalid_cycles=%0d want 1 1", obs_idle, obs_ivalid);
    else n_pass++;

    run_insn(4'd5, 10, 4'h3, 32'h12345678, 0);
    n_checks++;
    if (obs_writes !== 1 || {obs_ben, obs_addr, obs_data} !== {4'h3, 4'd5, 32'h12345678})
      $display("FAIL partial_ben got n=%0d wen=%h addr=%0d data=%h want 1 3 5 12345678",
               obs_writes, obs_ben, obs_addr, obs_data);
    else n_pass++;
    n_checks++;
    if (obs_lat !== 13 || obs_ivalid !== 11)
      $display("FAIL slow_unit got lat=%0d ivalid_cycles=%0d want 13 11", obs_lat, obs_ivalid);
    else n_pass++;

    run_insn(4'd0, 2, 4'hF, 32'h0BADF00D, 0);
    n_checks++;
    if (obs_writes !== 0 || obs_status !== 2'd0 || obs_lat !== 5)
      $display("FAIL rd_zero got writes=%0d st=%0d lat=%0d want 0 0 5", obs_writes, obs_status, obs_lat);
    else n_pass++;
  endtask

  task automatic test_rsp_hold();
    run_insn(4'd9, 1, 4'hC, 32'hA5A5_5A5A, 4);
    n_checks++;
    if (obs_rsp_cycles !== 5 || obs_status_stable !== 1'b1 || obs_status !== 2'd0)
      $display("FAIL rsp_hold got cycles=%0d stable=%b st=%0d want 5 1 0",
               obs_rsp_cycles, obs_status_stable, obs_status);
    else n_pass++;
    n_checks++;
    if (obs_ready_bad !== 1'b0)
      $display("FAIL ready_in_rsp got %b want 0", obs_ready_bad);
    else n_pass++;
    @(negedge clk);
    malu_idone = 1'b1; malu_cpr_rd_ben = 4'hF; malu_cpr_rd_wdata = 32'h11111111;
    @(negedge clk);
    malu_idone = 1'b0;
    obs_writes = 0; obs_rsp_cycles = 0;
    repeat (4) begin
      if (cpr_rd_wen != 0) obs_writes++;
      if (rsp_valid || malu_ivalid) obs_rsp_cycles++;
      @(negedge clk);
    end
    n_checks++;
    if (obs_writes !== 0 || obs_rsp_cycles !== 0 || insn_ready !== 1'b1)
      $display("FAIL stray_idone got writes=%0d activity=%0d ready=%b want 0 0 1",
               obs_writes, obs_rsp_cycles, insn_ready);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  rd, ben, exp_wen;
    logic [31:0] data;
    int          dly, rw;
    for (int t = 0; t < 24; t++) begin
      rd   = 4'($urandom_range(0, 15));
      ben  = 4'($urandom_range(0, 15));
      data = $urandom;
      dly  = $urandom_range(0, 5);
      rw   = $urandom_range(0, 2);
      exp_wen = (rd == 4'd0) ? 4'b0 : ben;
      if (exp_wen != 4'b0) exp_q.push_back({exp_wen, rd, data});
      run_insn(rd, dly, ben, data, rw);
      n_checks++;
      if (exp_wen != 4'b0) begin
        if (obs_writes !== 1 || exp_q.size() == 0 || {obs_ben, obs_addr, obs_data} !== exp_q[0])
          $display("FAIL rand_write t=%0d got n=%0d %h want 1 %h", t, obs_writes,
                   {obs_ben, obs_addr, obs_data}, {exp_wen, rd, data});
        else n_pass++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else begin
        if (obs_writes !== 0)
          $display("FAIL rand_nowrite t=%0d got n=%0d want 0", t, obs_writes);
        else n_pass++;
      end
      n_checks++;
      if (obs_lat !== 3 + dly || obs_rsp_cycles !== rw + 1 || obs_status !== 2'd0 || obs_idle !== 1'b1)
        $display("FAIL rand_rsp t=%0d got lat=%0d rc=%0d st=%0d idle=%b want %0d %0d 0 1",
                 t, obs_lat, obs_rsp_cycles, obs_status, obs_idle, 3 + dly, rw + 1);
      else n_pass++;
    end
  endtask

`ifdef SCARV_COP_MALU_TIMEOUT_EN
  task automatic test_timeout();
    run_insn(4'd6, 1000, 4'hF, 32'h77777777, 0);
    n_checks++;
    if (obs_status !== 2'd1 || obs_writes !== 0 || obs_lat !== 9 || obs_ivalid !== 8)
      $display("FAIL timeout got st=%0d writes=%0d lat=%0d ivc=%0d want 1 0 9 8",
               obs_status, obs_writes, obs_lat, obs_ivalid);
    else n_pass++;
    run_insn(4'd6, 7, 4'hF, 32'h88888888, 0);
    n_checks++;
    if (obs_status !== 2'd0 || obs_writes !== 1 || obs_data !== 32'h88888888 || obs_lat !== 10)
      $display("FAIL idone_at_limit got st=%0d writes=%0d data=%h lat=%0d want 0 1 88888888 10",
               obs_status, obs_writes, obs_data, obs_lat);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_rsp_hold();
    test_back_to_back();
`ifdef SCARV_COP_MALU_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
